wb_bus_arbiter: RTL and testbench

- Two-master Wishbone B4 classic arbiter.
- Shares one external memory bus between the core's instruction fetch port and its load/store port.
- Sits between the core and the unified memory/interconnect.
- Round-robin on contention, grant held for a whole bus cycle, bus-watchdog timeout that returns an error to the stalled master.

---
 rtl/wb_bus_arbiter_pkg.sv | 32 +++
 rtl/wb_timeout_cnt.sv | 33 +++
 rtl/wb_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// master indices and the round-robin pick used when the bus is idle.
package wb_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  localparam logic M_INSTR = 1'b0;
  localparam logic M_DATA  = 1'b1;

  // A tie goes to the master that did not own the bus last.
  function automatic logic [1:0] arb_pick(input logic i_act,
                                          input logic d_act,
                                          input logic last_grant);
    logic [1:0] pick;
    pick = ST_IDLE;
    if (i_act && d_act) begin
      pick = (last_grant == M_INSTR) ? ST_GNT_D : ST_GNT_I;
    end else if (d_act) begin
      pick = ST_GNT_D;
    end else if (i_act) begin
      pick = ST_GNT_I;
    end
    return pick;
  endfunction

  function automatic logic state_owner(input logic [1:0] st);
    return (st == ST_GNT_D) ? M_DATA : M_INSTR;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus watchdog: counts stalled grant cycles and flags the cycle in which the
// count reaches TIMEOUT-1. Clear has priority over enable.
module wb_timeout_cnt
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone B4 classic arbiter: instruction and data ports share one
// memory bus, round-robin on contention, with a watchdog that errors stalled cycles.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic [AW-1:0]   iwbs_addr_i,
  input  logic [DW-1:0]   iwbs_dat_i,
  input  logic [DW/8-1:0] iwbs_sel_i,
  input  logic            iwbs_we_i,
  input  logic            iwbs_cyc_i,
  input  logic            iwbs_stb_i,
  output logic [DW-1:0]   iwbs_dat_o,
  output logic            iwbs_ack_o,
  output logic            iwbs_err_o,

  input  logic [AW-1:0]   dwbs_addr_i,
  input  logic [DW-1:0]   dwbs_dat_i,
  input  logic [DW/8-1:0] dwbs_sel_i,
  input  logic            dwbs_we_i,
  input  logic            dwbs_cyc_i,
  input  logic            dwbs_stb_i,
  output logic [DW-1:0]   dwbs_dat_o,
  output logic            dwbs_ack_o,
  output logic            dwbs_err_o,

  output logic [AW-1:0]   wbm_addr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,

  output logic [1:0]      grant_o
);

  logic [1:0] r_state;
  logic       r_last_grant;

  logic [1:0] w_state_nxt;
  logic       w_last_nxt;
  logic       w_i_act;
  logic       w_d_act;
  logic       w_gnt_i;
  logic       w_gnt_d;
  logic       w_granted;
  logic       w_owner;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_bus_resp;
  logic       w_term;
  logic       w_abort;
  logic       w_cnt_expire;
  logic       w_expire;
  logic       w_leave;
  logic       w_timeout_err;

  assign w_i_act    = iwbs_cyc_i & iwbs_stb_i;
  assign w_d_act    = dwbs_cyc_i & dwbs_stb_i;
  assign w_gnt_i    = (r_state == ST_GNT_I);
  assign w_gnt_d    = (r_state == ST_GNT_D);
  assign w_granted  = w_gnt_i | w_gnt_d;
  assign w_owner    = state_owner(r_state);
  assign w_own_cyc  = (w_owner == M_DATA) ? dwbs_cyc_i : iwbs_cyc_i;
  assign w_own_stb  = (w_owner == M_DATA) ? dwbs_stb_i : iwbs_stb_i;
  assign w_bus_resp = wbm_ack_i | wbm_err_i;

  assign w_term   = w_granted & w_own_stb & w_bus_resp;
  assign w_abort  = w_granted & ~w_own_cyc;
  assign w_expire = w_granted & w_cnt_expire;
  assign w_leave  = w_term | w_abort | w_expire;

  // A real termination in the expiry cycle suppresses the watchdog error.
  assign w_timeout_err = w_expire & ~w_bus_resp;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clr    (~w_granted),
    .i_en     (w_granted & ~w_bus_resp),
    .o_expire (w_cnt_expire)
  );

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = arb_pick(w_i_act, w_d_act, r_last_grant);
      end
      ST_GNT_I, ST_GNT_D: begin
        if (w_leave) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = w_owner;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= M_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Outputs decode straight from state, so an asynchronous reset clears them at once.
  always_comb begin
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_we_o   = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    case (r_state)
      ST_GNT_I: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_dat_o  = iwbs_dat_i;
        wbm_sel_o  = iwbs_sel_i;
        wbm_we_o   = iwbs_we_i;
        wbm_cyc_o  = iwbs_cyc_i & ~w_expire;
        wbm_stb_o  = iwbs_stb_i & ~w_expire;
      end
      ST_GNT_D: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        wbm_cyc_o  = dwbs_cyc_i & ~w_expire;
        wbm_stb_o  = dwbs_stb_i & ~w_expire;
      end
      default: ;
    endcase
  end

  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;

  assign iwbs_ack_o = w_gnt_i & wbm_ack_i;
  assign iwbs_err_o = w_gnt_i & (wbm_err_i | w_timeout_err);
  assign dwbs_ack_o = w_gnt_d & wbm_ack_i;
  assign dwbs_err_o = w_gnt_d & (wbm_err_i | w_timeout_err);

  assign grant_o = {w_gnt_d, w_gnt_i};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: an ownership-level model checked every
// negedge, plus hand-computed expectations for each scenario.
module tb_wb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;

  logic [AW-1:0]   iwbs_addr_i = '0;
  logic [DW-1:0]   iwbs_dat_i = '0;
  logic [DW/8-1:0] iwbs_sel_i = '0;
  logic            iwbs_we_i = 1'b0;
  logic            iwbs_cyc_i = 1'b0;
  logic            iwbs_stb_i = 1'b0;
  logic [DW-1:0]   iwbs_dat_o;
  logic            iwbs_ack_o;
  logic            iwbs_err_o;

  logic [AW-1:0]   dwbs_addr_i = '0;
  logic [DW-1:0]   dwbs_dat_i = '0;
  logic [DW/8-1:0] dwbs_sel_i = '0;
  logic            dwbs_we_i = 1'b0;
  logic            dwbs_cyc_i = 1'b0;
  logic            dwbs_stb_i = 1'b0;
  logic [DW-1:0]   dwbs_dat_o;
  logic            dwbs_ack_o;
  logic            dwbs_err_o;

  logic [AW-1:0]   wbm_addr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic            wbm_we_o;
  logic            wbm_cyc_o;
  logic            wbm_stb_o;
  logic [DW-1:0]   wbm_dat_i = '0;
  logic            wbm_ack_i;
  logic            wbm_err_i;
  logic [1:0]      grant_o;

  int vectors = 0;
  int miscompares = 0;

  // Memory slave: acks mem_lat cycles after stb first appears (-1 = never).
  int   mem_lat = -1;
  int   stb_age = 0;
  logic force_ack = 1'b0;
  logic force_err = 1'b0;

  assign wbm_ack_i = force_ack | ((mem_lat >= 0) && wbm_stb_o && (stb_age == mem_lat));
  assign wbm_err_i = force_err;

  always @(posedge clk) begin
    if (wbm_stb_o && !wbm_ack_i) stb_age <= stb_age + 1;
    else stb_age <= 0;
  end

  wb_bus_arbiter #(
    .AW (AW), .DW (DW), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .iwbs_addr_i (iwbs_addr_i),
    .iwbs_dat_i  (iwbs_dat_i),
    .iwbs_sel_i  (iwbs_sel_i),
    .iwbs_we_i   (iwbs_we_i),
    .iwbs_cyc_i  (iwbs_cyc_i),
    .iwbs_stb_i  (iwbs_stb_i),
    .iwbs_dat_o  (iwbs_dat_o),
    .iwbs_ack_o  (iwbs_ack_o),
    .iwbs_err_o  (iwbs_err_o),
    .dwbs_addr_i (dwbs_addr_i),
    .dwbs_dat_i  (dwbs_dat_i),
    .dwbs_sel_i  (dwbs_sel_i),
    .dwbs_we_i   (dwbs_we_i),
    .dwbs_cyc_i  (dwbs_cyc_i),
    .dwbs_stb_i  (dwbs_stb_i),
    .dwbs_dat_o  (dwbs_dat_o),
    .dwbs_ack_o  (dwbs_ack_o),
    .dwbs_err_o  (dwbs_err_o),
    .wbm_addr_o  (wbm_addr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .grant_o     (grant_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 instr, 2 data), how long it has waited, who owned last.
  int m_owner = 0, m_age = 0, m_last = 1;
  int n_owner = 0, n_age = 0, n_last = 1;

  always @(negedge clk) begin : compare
    logic [AW-1:0]   o_addr;
    logic [DW-1:0]   o_dat;
    logic [DW/8-1:0] o_sel;
    logic            o_we, o_cyc, o_stb, expired, resp, e_err;
    if (m_owner == 2) begin
      o_addr = dwbs_addr_i; o_dat = dwbs_dat_i; o_sel = dwbs_sel_i;
      o_we = dwbs_we_i; o_cyc = dwbs_cyc_i; o_stb = dwbs_stb_i;
    end else begin
      o_addr = iwbs_addr_i; o_dat = iwbs_dat_i; o_sel = iwbs_sel_i;
      o_we = iwbs_we_i; o_cyc = iwbs_cyc_i; o_stb = iwbs_stb_i;
    end
    expired = (m_owner != 0) && (m_age == TIMEOUT - 1);
    resp = wbm_ack_i | wbm_err_i;
    e_err = wbm_err_i | (expired & !resp);

    if (m_owner == 0) begin
      check("idle_addr", wbm_addr_o, 0);
      check("idle_dat", wbm_dat_o, 0);
      check("idle_sel", wbm_sel_o, 0);
      check("idle_we", wbm_we_o, 0);
      check("idle_cyc", wbm_cyc_o, 0);
      check("idle_stb", wbm_stb_o, 0);
    end else begin
      check("bus_addr", wbm_addr_o, o_addr);
      check("bus_dat", wbm_dat_o, o_dat);
      check("bus_sel", wbm_sel_o, o_sel);
      check("bus_we", wbm_we_o, o_we);
      check("bus_cyc", wbm_cyc_o, o_cyc & !expired);
      check("bus_stb", wbm_stb_o, o_stb & !expired);
    end
    check("grant", grant_o, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
    check("i_ack", iwbs_ack_o, (m_owner == 1) & wbm_ack_i);
    check("i_err", iwbs_err_o, (m_owner == 1) & e_err);
    check("d_ack", dwbs_ack_o, (m_owner == 2) & wbm_ack_i);
    check("d_err", dwbs_err_o, (m_owner == 2) & e_err);
    check("i_dat", iwbs_dat_o, wbm_dat_i);
    check("d_dat", dwbs_dat_o, wbm_dat_i);

    if (m_owner == 0) begin
      bit ia, da;
      ia = iwbs_cyc_i & iwbs_stb_i;
      da = dwbs_cyc_i & dwbs_stb_i;
      if (ia && da) n_owner = (m_last == 2) ? 1 : 2;
      else if (da) n_owner = 2;
      else if (ia) n_owner = 1;
      else n_owner = 0;
      n_age = 0;
      n_last = m_last;
    end else if ((resp && o_stb) || !o_cyc || expired) begin
      n_owner = 0;
      n_age = 0;
      n_last = m_owner;
    end else begin
      n_owner = m_owner;
      n_age = m_age + (resp ? 0 : 1);
      n_last = m_last;
    end
  end

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_owner <= 0; m_age <= 0; m_last <= 1;
    end else begin
      m_owner <= n_owner; m_age <= n_age; m_last <= n_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #2;
  endtask

  task automatic i_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    iwbs_addr_i = a; iwbs_we_i = we; iwbs_dat_i = d; iwbs_sel_i = 4'hF;
    iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
  endtask

  task automatic d_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    dwbs_addr_i = a; dwbs_we_i = we; dwbs_dat_i = d; dwbs_sel_i = 4'hF;
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
  endtask

  task automatic i_drop();
    iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
  endtask

  task automatic d_drop();
    dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
  endtask

  initial begin
    #1 rst_i = 1'b0;

    // Reset held with I requesting: bus stays quiet.
    i_req(32'h0000_0100, 1'b0, 32'h0);
    step(); step(); peek();
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_grant", grant_o, 2'b00);
    check("rst_i_ack", iwbs_ack_o, 0);
    check("rst_i_err", iwbs_err_o, 0);
    step(); rst_i = 1'b1;
    step(); peek();
    check("rel_grant", grant_o, 2'b01);
    check("rel_addr", wbm_addr_o, 32'h0000_0100);
    step(); i_drop(); peek();
    check("drop_cyc", wbm_cyc_o, 0);
    step();

    // Continuous contention, 1-cycle ack: D, I, D, I with an IDLE cycle between grants.
    begin
      logic [1:0] seq[4];
      int ng = 0, idles = 0, iacks = 0, dacks = 0;
      mem_lat = 0;
      for (int c = 0; c < 16; c++) begin
        step();
        if (c == 0) begin
          i_req(32'h0000_0200, 1'b0, 32'h0);
          d_req(32'h0000_0300, 1'b1, 32'h0000_A5A5);
        end
        peek();
        if (grant_o == 2'b00) idles++;
        else if (ng < 4 && (c % 2) == 1) begin
          seq[ng] = grant_o;
          ng++;
        end
        if (c == 1) check("cont_addr", wbm_addr_o, 32'h0000_0300);
        if (iwbs_ack_o) iacks++;
        if (dwbs_ack_o) dacks++;
      end
      check("cont_ngrants", ng, 4);
      check("cont_g0", seq[0], 2'b10);
      check("cont_g1", seq[1], 2'b01);
      check("cont_g2", seq[2], 2'b10);
      check("cont_g3", seq[3], 2'b01);
      check("cont_idles", idles, 8);
      check("cont_i_acks", iacks, 4);
      check("cont_d_acks", dacks, 4);
      step(); i_drop(); d_drop();
      step();
    end

    // Single data read acked 2 cycles after stb.
    begin
      int dacks = 0, iacks = 0, ack_c = -1;
      logic [31:0] rdat = '0;
      mem_lat = 2;
      wbm_dat_i = 32'hDEAD_BEEF;
      for (int c = 0; c < 10; c++) begin
        step();
        if (c == 0) d_req(32'h0000_1000, 1'b0, 32'h0);
        if (dacks > 0) d_drop();
        peek();
        if (dwbs_ack_o) begin
          dacks++; rdat = dwbs_dat_o; ack_c = c;
        end
        if (iwbs_ack_o) iacks++;
      end
      check("rd_ack_count", dacks, 1);
      check("rd_ack_cycle", ack_c, 3);
      check("rd_data", rdat, 32'hDEAD_BEEF);
      check("rd_i_acks", iacks, 0);
      wbm_dat_i = 32'h0;
    end

    // Data write never acked: watchdog errors on the 8th grant cycle.
    begin
      int gcnt = 0, errs = 0, err_g = -1;
      logic cyc_at_err = 1'b1;
      logic [1:0] g9 = 2'b11;
      mem_lat = -1;
      for (int c = 0; c < 13; c++) begin
        step();
        if (c == 0) d_req(32'h0000_0400, 1'b1, 32'h1234_5678);
        if (errs > 0) d_drop();
        peek();
        if (grant_o == 2'b10) gcnt++;
        if (c == 1) check("to_wdat", wbm_dat_o, 32'h1234_5678);
        if (c == 9) g9 = grant_o;
        if (dwbs_err_o) begin
          errs++; err_g = gcnt; cyc_at_err = wbm_cyc_o;
        end
      end
      check("to_err_grant_cycle", err_g, 8);
      check("to_err_pulses", errs, 1);
      check("to_cyc_at_err", cyc_at_err, 0);
      check("to_idle_after", g9, 2'b00);
    end

    // Abort by I with D pending; a late ack in IDLE is ignored; then async reset in GNT_D.
    step(); i_req(32'h0000_0500, 1'b0, 32'h0); peek();
    step(); d_req(32'h0000_0600, 1'b0, 32'h0); peek();
    check("ab_grant_i", grant_o, 2'b01);
    step(); i_drop(); peek();
    check("ab_cyc", wbm_cyc_o, 0);
    check("ab_i_ack", iwbs_ack_o, 0);
    step(); force_ack = 1'b1; peek();
    check("late_ack_i", iwbs_ack_o, 0);
    check("late_ack_d", dwbs_ack_o, 0);
    check("late_grant", grant_o, 2'b00);
    step(); force_ack = 1'b0; peek();
    check("ab_grant_d", grant_o, 2'b10);
    check("ab_addr_d", wbm_addr_o, 32'h0000_0600);

    rst_i = 1'b0;
    i_req(32'h0000_0700, 1'b0, 32'h0);
    #1;
    check("arst_cyc", wbm_cyc_o, 0);
    check("arst_stb", wbm_stb_o, 0);
    check("arst_addr", wbm_addr_o, 0);
    check("arst_grant", grant_o, 2'b00);
    check("arst_d_err", dwbs_err_o, 0);
    step();
    step(); rst_i = 1'b1;
    step(); peek();
    check("arst_tie_d", grant_o, 2'b10);
    step(); i_drop(); d_drop();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
